// File: rtl/output_logic.sv
// Router transmit side: drains three packet FIFOs onto independent req/ack output
// channels and uses each header's length field to find where the packet ends.
module output_logic #(
   parameter int DATA_WIDTH = 8,
   parameter int DATA_SIZE  = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [3*DATA_WIDTH-1:0] fifo_data_out,
   input  logic [2:0]              fifo_empty,
   output logic [2:0]              fifo_pop,
   output logic [3*DATA_WIDTH-1:0] data_out,
   output logic [2:0]              data_out_req,
   input  logic [2:0]              data_out_ack,
   input  logic                    crc_en,
   output logic [2:0]              ch_busy
);
   localparam int REM_W = DATA_SIZE + 1;

   typedef enum logic [1:0] { IDLE, BODY, LAST } state_t;

   for (genvar i = 0; i < 3; i++) begin : g_ch
      state_t                state, state_nxt;
      logic [REM_W-1:0]      rem, rem_nxt, hdr_rem;
      logic [DATA_WIDTH-1:0] head, data_q;
      logic                  req_q, busy_q, busy_nxt;
      logic                  ack, permit, load, take_hdr;

      assign head     = fifo_data_out[i*DATA_WIDTH +: DATA_WIDTH];
      assign ack      = data_out_ack[i];
      assign hdr_rem  = REM_W'(head[2 +: DATA_SIZE]) + REM_W'(crc_en);
      // The next header may enter the stage only as the final byte is accepted.
      assign permit   = (state != LAST) || ack;
      assign load     = (!req_q || ack) && !fifo_empty[i] && permit;
      assign take_hdr = load && ((state == IDLE) || (state == LAST));

      always_comb begin
         // NOTE: every output of this block gets a default first, so no path can infer a latch.
         state_nxt = state;
         rem_nxt   = rem;
         busy_nxt  = busy_q;
         if (take_hdr) begin
            rem_nxt   = hdr_rem;
            state_nxt = (hdr_rem == '0) ? LAST : BODY;
            busy_nxt  = (hdr_rem != '0);
         end else begin
            case (state)
               BODY: begin
                  if (load) begin
                     rem_nxt = rem - REM_W'(1);
                     if (rem == REM_W'(1)) state_nxt = LAST;
                  end
               end
               LAST: begin
                  if (ack) begin
                     state_nxt = IDLE;
                     busy_nxt  = 1'b0;
                  end
               end
               default: state_nxt = IDLE;
            endcase
         end
      end

      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= IDLE;
            rem    <= '0;
            data_q <= '0;
            req_q  <= 1'b0;
            busy_q <= 1'b0;
         end else begin
            state  <= state_nxt;
            rem    <= rem_nxt;
            busy_q <= busy_nxt;
            if (load) begin
               data_q <= head;
               req_q  <= 1'b1;
            end else if (ack) begin
               req_q  <= 1'b0;
            end
         end
      end

      // Pop is held low during reset so no FIFO entry is consumed while the stage is cleared.
      assign fifo_pop[i]                           = load && rst_n;
      assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign data_out_req[i]                       = req_q;
      assign ch_busy[i]                            = busy_q;
   end
endmodule

// File: tb/tb_output_logic.sv
// Bench for output_logic: directed vector table on channel 0, reset sequence on all
// channels, then randomized traffic checked against a byte-stream reference model.
module tb_output_logic;
   localparam int W     = 8;
   localparam int DEPTH = 8192;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [3*W-1:0] fifo_data_out;
   logic [2:0]     fifo_empty;
   logic [2:0]     fifo_pop;
   logic [3*W-1:0] data_out;
   logic [2:0]     data_out_req;
   logic [2:0]     data_out_ack;
   logic           crc_en;
   logic [2:0]     ch_busy;

   output_logic #(.DATA_WIDTH(W), .DATA_SIZE(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fifo_data_out(fifo_data_out),
      .fifo_empty   (fifo_empty),
      .fifo_pop     (fifo_pop),
      .data_out     (data_out),
      .data_out_req (data_out_req),
      .data_out_ack (data_out_ack),
      .crc_en       (crc_en),
      .ch_busy      (ch_busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Bench FIFOs: everything ever pushed per channel; fr advances on DUT pops.
   logic [W-1:0] strm [3][DEPTH];
   int           fr [3];
   int           wr [3];
   logic [2:0]   pop_s;

   // Reference model: p = bytes popped, d = bytes delivered, hdr = index of next
   // header, [cs, ce] = span of the packet that owns the most recently popped byte.
   int   p [3], d [3], hdr [3], cs [3], ce [3];
   int   gen_left [3];
   logic m_req, m_pop, m_busy;

   typedef struct {
      logic         push;
      logic [W-1:0] din;
      logic         ack;
      logic         crc;
      logic         er;
      logic [W-1:0] ed;
      logic         ep;
      logic         eb;
   } vec_t;
   vec_t tbl [$];

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic push, input logic [W-1:0] din, input logic ack,
                      input logic crc, input logic er, input logic [W-1:0] ed,
                      input logic ep, input logic eb);
      vec_t v;
      v = '{push, din, ack, crc, er, ed, ep, eb};
      tbl.push_back(v);
   endtask

   task automatic push(input int ch, input logic [W-1:0] b);
      if (wr[ch] < DEPTH) begin
         strm[ch][wr[ch]] = b;
         wr[ch]++;
      end
   endtask

   task automatic drive_fifo();
      for (int i = 0; i < 3; i++) begin
         fifo_empty[i] = (fr[i] == wr[i]);
         fifo_data_out[i*W +: W] = fifo_empty[i] ? '0 : strm[i][fr[i]];
      end
   endtask

   task automatic end_cycle();
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++)
         if (pop_s[i] && (fr[i] != wr[i])) fr[i]++;
      drive_fifo();
   endtask

   task automatic model_rebase();
      for (int i = 0; i < 3; i++) begin
         p[i]   = wr[i] < fr[i] ? wr[i] : fr[i];
         d[i]   = p[i];
         hdr[i] = p[i];
         cs[i]  = 0;
         ce[i]  = -1;
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      data_out_ack = '0;
      crc_en       = 1'b0;
      pop_s        = '0;
      for (int i = 0; i < 3; i++) begin
         fr[i] = 0;
         wr[i] = 0;
         gen_left[i] = 0;
      end
      drive_fifo();

      // push, din, ack, crc | req, data, pop, busy   (channel 0)
      // L=3, no CRC, ack held high
      add(1, 8'h0D, 1, 0,  0, 8'h00, 1, 0);
      add(1, 8'hA1, 1, 0,  1, 8'h0D, 1, 1);
      add(1, 8'hA2, 1, 0,  1, 8'hA1, 1, 1);
      add(1, 8'hA3, 1, 0,  1, 8'hA2, 1, 1);
      add(0, 8'h00, 1, 0,  1, 8'hA3, 0, 1);
      add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      // L=3 with CRC; crc_en dropped right after the header
      add(1, 8'h0D, 1, 1,  0, 8'h00, 1, 0);
      add(1, 8'hC1, 1, 0,  1, 8'h0D, 1, 1);
      add(1, 8'hC2, 1, 0,  1, 8'hC1, 1, 1);
      add(1, 8'hC3, 1, 0,  1, 8'hC2, 1, 1);
      add(1, 8'hCC, 1, 0,  1, 8'hC3, 1, 1);
      add(0, 8'h00, 1, 0,  1, 8'hCC, 0, 1);
      add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      // backpressure on the second byte for three cycles
      add(1, 8'h0D, 1, 0,  0, 8'h00, 1, 0);
      add(1, 8'hB1, 1, 0,  1, 8'h0D, 1, 1);
      add(1, 8'hB2, 0, 0,  1, 8'hB1, 0, 1);
      add(1, 8'hB3, 0, 0,  1, 8'hB1, 0, 1);
      add(0, 8'h00, 0, 0,  1, 8'hB1, 0, 1);
      add(0, 8'h00, 1, 0,  1, 8'hB1, 1, 1);
      add(0, 8'h00, 1, 0,  1, 8'hB2, 1, 1);
      add(0, 8'h00, 1, 0,  1, 8'hB3, 0, 1);
      add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      // underrun: L=2, final byte arrives late
      add(1, 8'h09, 1, 0,  0, 8'h00, 1, 0);
      add(1, 8'hD1, 1, 0,  1, 8'h09, 1, 1);
      add(0, 8'h00, 1, 0,  1, 8'hD1, 0, 1);
      add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1);
      add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1);
      add(1, 8'hD2, 1, 0,  0, 8'h00, 1, 1);
      add(0, 8'h00, 1, 0,  1, 8'hD2, 0, 1);
      add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
      // L=0 single-byte packet, then L=1 packet back to back
      add(1, 8'h02, 1, 0,  0, 8'h00, 1, 0);
      add(1, 8'h05, 1, 0,  1, 8'h02, 1, 0);
      add(1, 8'hE1, 1, 0,  1, 8'h05, 1, 1);
      add(0, 8'h00, 1, 0,  1, 8'hE1, 0, 1);
      add(0, 8'h00, 1, 0,  0, 8'h00, 0, 0);

      #12;
      check("reset_req",  0, data_out_req, 3'b000);
      check("reset_data", 0, data_out, '0);
      check("reset_busy", 0, ch_busy, 3'b000);
      check("reset_pop",  0, fifo_pop, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int r = 0; r < tbl.size(); r++) begin
         if (tbl[r].push) push(0, tbl[r].din);
         data_out_ack = {2'b11, tbl[r].ack};
         crc_en       = tbl[r].crc;
         drive_fifo();
         @(negedge clk);
         pop_s = fifo_pop;
         check("tbl_req",  r, data_out_req[0], tbl[r].er);
         check("tbl_pop",  r, fifo_pop[0], tbl[r].ep);
         check("tbl_busy", r, ch_busy[0], tbl[r].eb);
         if (tbl[r].er) check("tbl_data", r, data_out[W-1:0], tbl[r].ed);
         end_cycle();
      end

      // Reset in the middle of a packet on every channel.
      data_out_ack = 3'b111;
      crc_en       = 1'b0;
      for (int i = 0; i < 3; i++) begin
         push(i, 8'h0D);
         push(i, 8'h31 + 8'(i));
         push(i, 8'h04 + 8'(i));
         push(i, 8'h70 + 8'(i));
      end
      drive_fifo();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         pop_s = fifo_pop;
         end_cycle();
      end
      check("pre_rst_busy", 0, ch_busy, 3'b111);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_req",  0, data_out_req, 3'b000);
      check("async_rst_data", 0, data_out, '0);
      check("async_rst_busy", 0, ch_busy, 3'b000);
      check("async_rst_pop",  0, fifo_pop, 3'b000);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         pop_s = fifo_pop;
         for (int i = 0; i < 3; i++) begin
            check("post_rst_req",  c*3+i, data_out_req[i], (c == 1) || (c == 2));
            check("post_rst_pop",  c*3+i, fifo_pop[i], c < 2);
            check("post_rst_busy", c*3+i, ch_busy[i], (c == 1) || (c == 2));
            if (c == 1) check("post_rst_hdr", i, data_out[i*W +: W], 8'h04 + i);
            if (c == 2) check("post_rst_pay", i, data_out[i*W +: W], 8'h70 + i);
         end
         end_cycle();
      end

      // Randomized traffic against the stream model.
      model_rebase();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc == 700) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
            model_rebase();
         end
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 9) < 6) begin
               if (gen_left[i] == 0) begin
                  int len;
                  len = $urandom_range(0, 4);
                  push(i, {6'(len), 2'(i)});
                  gen_left[i] = len + int'(crc_en);
               end else begin
                  push(i, 8'($urandom));
                  gen_left[i]--;
               end
            end
            data_out_ack[i] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 49) == 0) crc_en = ~crc_en;
         drive_fifo();
         @(negedge clk);
         pop_s = fifo_pop;
         for (int i = 0; i < 3; i++) begin
            m_req  = p[i] > d[i];
            m_pop  = (p[i] < wr[i]) && (!m_req || data_out_ack[i]);
            m_busy = (ce[i] > cs[i]) && (d[i] <= ce[i]);
            check("rnd_req",  cyc*3+i, data_out_req[i], m_req);
            check("rnd_pop",  cyc*3+i, fifo_pop[i], m_pop);
            check("rnd_busy", cyc*3+i, ch_busy[i], m_busy);
            if (m_req) check("rnd_data", cyc*3+i, data_out[i*W +: W], strm[i][d[i]]);
            if (m_req && data_out_ack[i]) d[i]++;
            if (m_pop) begin
               if (p[i] == hdr[i]) begin
                  cs[i]  = p[i];
                  ce[i]  = p[i] + int'(strm[i][p[i]][7:2]) + int'(crc_en);
                  hdr[i] = ce[i] + 1;
               end
               p[i]++;
            end
         end
         end_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/output_logic.md
Name: output_logic

Overview:
- Transmit side of the router: drains the three per-channel packet FIFOs and drives each output channel with a req/ack handshake.
- Sits between the fifo_synch instances (pop side) and the top-level data_out/data_out_req/data_out_ack ports.
- The three channels run independently. Each one parses the packet header to frame the packet and forwards header, payload and optional CRC byte unchanged.

Parameters:
DATA_WIDTH, 8, byte width of FIFO entries and output data
DATA_SIZE, 6, width of header length field (max 63 payload bytes)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
fifo_data_out  input  3*DATA_WIDTH  head entry of FIFO i at bits [i*DATA_WIDTH +: DATA_WIDTH]; first-word fall-through, valid when !fifo_empty[i]
fifo_empty  input  3  FIFO i empty
fifo_pop  output  3  pop FIFO i; head advances on next clk
data_out  output  3*DATA_WIDTH  channel i output byte, registered
data_out_req  output  3  channel i byte valid
data_out_ack  input  3  channel i consumer accepts byte
crc_en  input  1  from config_regs; packet carries trailing CRC byte
ch_busy  output  3  channel i mid-packet (header sent, last byte not yet accepted)

Behaviour:
- Reset: fifo_pop=0, data_out=0, data_out_req=0, ch_busy=0. All channel FSMs go to IDLE and all counters clear. Reset mid-packet abandons the packet; no partial resume.
- Header format: bits [1:0] = address (forwarded, not checked); bits [7:2] = payload length L (0..63).
- Transfer: a byte is delivered in a cycle where data_out_req[i] & data_out_ack[i].
  - While req=1 and ack=0, data_out[i] and req are held stable.
  - ack while req=0 is ignored.
- Output stage load condition: load when (!req | ack) & !fifo_empty[i] & FSM permits.
  - On load: fifo_pop[i]=1 in the same cycle (combinational), data_out[i] <= head, req <= 1 at next edge.
  - If ack and no load: req <= 0.
  - Throughput is 1 byte/cycle per channel with ack held high. Latency from non-empty FIFO to req is 1 cycle.
- Per-channel FSM:
  - IDLE: on header load, latch rem = L + crc_en (7-bit, max 64); crc_en is sampled only here. If rem==0, go to LAST; else go to BODY and set ch_busy.
  - BODY: each load decrements rem. On the load where rem becomes 0, go to LAST.
  - LAST: wait for the ack of the final byte, then go to IDLE and clear ch_busy. This final ack is the completion event.
  - The header of the next packet may be loaded in the same cycle the last byte is acked, giving back-to-back packets with no bubble. The FSM then goes directly to BODY/LAST for the new packet.
- FIFO empty mid-packet: no load. req drops after the pending byte is acked. The FSM holds state and rem, and resumes when non-empty. There is no timeout.
- fifo_pop is never asserted while fifo_empty[i]=1, and never more than once per loaded byte.
- Channels share no state; simultaneous activity on all three channels is fully parallel.
- crc_en changing mid-packet does not affect the current packet.

Test Plan:
1. Channel 0 FIFO holds 0x0D,0xA1,0xA2,0xA3 (L=3), crc_en=0, ack tied 1 -> req high 4 consecutive cycles carrying 0x0D,A1,A2,A3; 4 pops; ch_busy high from cycle after header through final ack; then IDLE.
2. Same packet with crc_en=1 and FIFO holding 5 bytes -> 5 bytes forwarded. Toggling crc_en to 0 after the header does not truncate the packet.
3. Backpressure: ack low for 3 cycles on byte 2 -> data_out/req stable for those cycles, fifo_pop=0, no byte lost or duplicated.
4. FIFO underrun: only header plus 1 payload of an L=2 packet present -> req drops after byte 2 is acked, ch_busy stays 1. Pushing the final byte resumes the packet and completes it.
5. Header 0x02 (L=0), crc_en=0 -> single-byte packet, immediately IDLE. A following packet is back-to-back with no idle cycle.
6. Assert rst_n=0 mid-packet on channel 1 while channels 0 and 2 are active -> all outputs 0 asynchronously. After release, the next FIFO byte is treated as a header on every channel.
